// File: rtl/spi_frame_arbiter.sv
// rtl/spi_frame_arbiter.sv - round-robin arbiter sharing one SPI byte engine among N_REQ requesters
// Holds the granted slave select across a whole frame and enforces CS setup/hold/gap timing.
module spi_frame_arbiter #(
  parameter int N_REQ    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_last,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 eng_start,
  output logic [7:0]           eng_tx,
  input  logic                 eng_busy,
  input  logic                 eng_done,
  input  logic [7:0]           eng_rx,
  output logic [N_REQ-1:0]     ss_n,
  output logic                 busy
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_XFER, S_HOLD, S_GAP} state_t;

  state_t             state_q;
  logic [2:0]         grant_q;
  logic [2:0]         ptr_q;
  logic               last_q;
  logic [15:0]        cnt_q;
  logic [N_REQ-1:0]   ss_n_q;
  logic               busy_q;
  logic               rsp_valid_q;
  logic [2:0]         rsp_id_q;
  logic [7:0]         rsp_data_q;

  logic               g_valid;
  logic               g_last;
  logic [7:0]         g_data;
  logic [N_REQ-1:0]   g_onehot;
  logic [2:0]         pick;
  logic [N_REQ-1:0]   pick_oh;

  always_comb begin
    g_valid  = 1'b0;
    g_last   = 1'b0;
    g_data   = 8'h00;
    g_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        g_valid     = req_valid[i];
        g_last      = req_last[i];
        g_data      = req_data[8*i +: 8];
        g_onehot[i] = 1'b1;
      end
    end
  end

  // Walk from farthest to nearest so the first requester after ptr wins.
  always_comb begin
    pick    = 3'd0;
    pick_oh = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (req_valid[j] && (j == (int'(ptr_q) + k) % N_REQ)) begin
          pick    = 3'(j);
          pick_oh = '0;
          pick_oh[j] = 1'b1;
        end
      end
    end
  end

  assign eng_start = (state_q == S_LOAD) && g_valid && !eng_busy;
  assign req_ready = eng_start ? g_onehot : '0;
  assign eng_tx    = eng_start ? g_data : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 3'd0;
      ptr_q       <= 3'(N_REQ-1);
      last_q      <= 1'b0;
      cnt_q       <= 16'd0;
      ss_n_q      <= '1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 3'd0;
      rsp_data_q  <= 8'h00;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            grant_q <= pick;
            ptr_q   <= pick;
            cnt_q   <= 16'd0;
            ss_n_q  <= ~pick_oh;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q == 16'(CS_SETUP-1)) begin
            cnt_q   <= 16'd0;
            state_q <= S_LOAD;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_LOAD: begin
          if (eng_start) begin
            last_q  <= g_last;
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if (eng_done) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= grant_q;
            rsp_data_q  <= eng_rx;
            cnt_q       <= 16'd0;
            state_q     <= last_q ? S_HOLD : S_LOAD;
          end
        end
        S_HOLD: begin
          if (cnt_q == 16'(CS_HOLD-1)) begin
            cnt_q   <= 16'd0;
            ss_n_q  <= '1;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == 16'(CS_GAP-1)) begin
            cnt_q   <= 16'd0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          ss_n_q  <= '1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ss_n      = ss_n_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// tb/tb_spi_frame_arbiter.sv - directed bench for spi_frame_arbiter
// Requester queues and a 16-cycle engine model feed the DUT; a negedge monitor logs events.
module tb_spi_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_ready, ss_n;
  logic [31:0] req_data;
  logic        rsp_valid, eng_start, eng_busy, eng_done, busy;
  logic [2:0]  rsp_id;
  logic [7:0]  rsp_data, eng_tx, eng_rx;

  logic        eng_busy_m, eng_busy_x, eng_done_m, eng_done_x, eng_auto;
  logic [7:0]  rx_m, rx_x, rx_key, tx_cap;

  assign eng_busy = eng_busy_m | eng_busy_x;
  assign eng_done = eng_done_m | eng_done_x;
  assign eng_rx   = eng_done_x ? rx_x : rx_m;

  spi_frame_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .eng_start(eng_start), .eng_tx(eng_tx), .eng_busy(eng_busy), .eng_done(eng_done), .eng_rx(eng_rx),
    .ss_n(ss_n), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Event logs filled by the monitor.
  int         st_cyc[$];
  logic [7:0] st_tx[$];
  int         rdy_cyc[$];
  logic [2:0] rdy_id[$];
  logic [10:0] rsp_log[$];
  int         ss_low = 0, ss_runs = 0, viol = 0;
  logic [3:0] ss_seen = 4'hF;
  logic       prev_low = 1'b0;

  always @(negedge clk) begin
    if (eng_start) begin st_cyc.push_back(cyc_n); st_tx.push_back(eng_tx); end
    if (req_ready != 4'h0) begin
      rdy_cyc.push_back(cyc_n);
      for (int i = 0; i < 4; i++) if (req_ready[i]) rdy_id.push_back(3'(i));
    end
    if (rsp_valid) rsp_log.push_back({rsp_id, rsp_data});
    if (ss_n != 4'hF) begin
      ss_low++;
      ss_seen = ss_n;
      if (!prev_low) ss_runs++;
    end
    prev_low = (ss_n != 4'hF);
    if (!$onehot0(req_ready) || !$onehot0(~ss_n) || ((req_ready & ss_n) != 4'h0)) viol++;
  end

  function automatic int st_at(int i);
    return (i < st_cyc.size()) ? st_cyc[i] : -1000;
  endfunction
  function automatic logic [7:0] tx_at(int i);
    return (i < st_tx.size()) ? st_tx[i] : 8'hXX;
  endfunction
  function automatic logic [2:0] rdy_at(int i);
    return (i < rdy_id.size()) ? rdy_id[i] : 3'h7;
  endfunction
  function automatic logic [10:0] rsp_at(int i);
    return (i < rsp_log.size()) ? rsp_log[i] : 11'h7FF;
  endfunction

  task automatic clear_logs();
    st_cyc.delete(); st_tx.delete(); rdy_cyc.delete(); rdy_id.delete(); rsp_log.delete();
    ss_low = 0; ss_runs = 0; ss_seen = 4'hF;
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(string tag);
    int n = 0;
    step(2);
    while (busy && n < 400) begin step(1); n++; end
    chk(tag, 64'(n < 400), 64'd1);
  endtask

  // Requester model: presents queue heads, pops on the accepted cycle.
  typedef logic [8:0] beat_t;
  typedef beat_t beat_q_t[$];
  beat_q_t fq [4];
  logic [3:0] rdy_seen;
  beat_t      dropped;

  initial begin
    req_valid = '0; req_last = '0; req_data = '0;
    forever begin
      @(negedge clk); rdy_seen = req_ready;
      @(posedge clk); #2;
      for (int i = 0; i < 4; i++) begin
        if (rdy_seen[i] && fq[i].size() > 0) dropped = fq[i].pop_front();
        if (fq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_last[i]  = fq[i][0][8];
          req_data[8*i +: 8] = fq[i][0][7:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Engine model: start at cycle S, busy S+1..S+15, done at S+15 with rx = tx ^ rx_key.
  initial begin
    eng_busy_m = 1'b0; eng_done_m = 1'b0; rx_m = 8'h00;
    forever begin
      @(negedge clk);
      if (eng_start && eng_auto) begin
        tx_cap = eng_tx;
        @(posedge clk); #1 eng_busy_m = 1'b1;
        repeat (14) @(posedge clk);
        #1 eng_done_m = 1'b1; rx_m = tx_cap ^ rx_key;
        @(posedge clk); #1 eng_done_m = 1'b0; eng_busy_m = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1; eng_busy_x = 1'b0; eng_done_x = 1'b0; rx_x = 8'h00;
    eng_auto = 1'b1; rx_key = 8'h99;
    step(3);
    chk("rst_ss_n", 64'(ss_n), 64'hF);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready_start_rspv", 64'({req_ready, eng_start, rsp_valid}), 64'd0);
    chk("rst_rsp_id_data", 64'({rsp_id, rsp_data}), 64'd0);
    chk("rst_eng_tx", 64'(eng_tx), 64'd0);
    rst = 1'b0;
    step(2);

    // Single-byte frame from requester 2.
    clear_logs();
    t0 = cyc_n;
    fq[2].push_back({1'b1, 8'hA5});
    wait_done("single_timeout");
    chk("single_end_cycle", 64'(cyc_n - t0), 64'd22);
    chk("single_starts", 64'(st_cyc.size()), 64'd1);
    chk("single_first_start", 64'(st_at(0) - t0), 64'd3);
    chk("single_tx", 64'(tx_at(0)), 64'hA5);
    chk("single_rsp_count", 64'(rsp_log.size()), 64'd1);
    chk("single_rsp", 64'(rsp_at(0)), 64'h23C);
    chk("single_ss_value", 64'(ss_seen), 64'hB);
    chk("single_ss_low_cycles", 64'(ss_low), 64'd20);
    chk("single_ss_runs", 64'(ss_runs), 64'd1);

    // Round-robin order from reset; requester 0 re-requests after its frame.
    rst = 1'b1; step(2); rst = 1'b0;
    clear_logs();
    for (int i = 0; i < 4; i++) fq[i].push_back({1'b1, 8'(8'h10 + i)});
    wait_done("rr_f0_timeout");
    fq[0].push_back({1'b1, 8'h20});
    repeat (4) wait_done("rr_timeout");
    chk("rr_ready_count", 64'(rdy_id.size()), 64'd5);
    chk("rr_order", 64'({rdy_at(0), rdy_at(1), rdy_at(2), rdy_at(3), rdy_at(4)}),
        64'({3'd0, 3'd1, 3'd2, 3'd3, 3'd0}));
    chk("rr_rsp_first", 64'(rsp_at(0)), 64'h089);
    chk("rr_rsp_third", 64'(rsp_at(2)), 64'h28B);
    chk("rr_rsp_last", 64'(rsp_at(4)), 64'h0B9);
    chk("rr_ss_runs", 64'(ss_runs), 64'd5);

    // Three-byte frame from requester 1.
    clear_logs();
    rx_key = 8'h5A;
    fq[1].push_back({1'b0, 8'h11});
    fq[1].push_back({1'b0, 8'h22});
    fq[1].push_back({1'b1, 8'h33});
    wait_done("multi_timeout");
    chk("multi_ready_ids", 64'({rdy_id.size() == 3, rdy_at(0), rdy_at(1), rdy_at(2)}),
        64'({1'b1, 3'd1, 3'd1, 3'd1}));
    chk("multi_tx", 64'({tx_at(0), tx_at(1), tx_at(2)}), 64'h112233);
    chk("multi_rsp_count", 64'(rsp_log.size()), 64'd3);
    chk("multi_rsp", 64'({rsp_at(0), rsp_at(1), rsp_at(2)}), 64'({11'h14B, 11'h178, 11'h169}));
    chk("multi_spacing", 64'({16'(st_at(1) - st_at(0)), 16'(st_at(2) - st_at(1))}), 64'h0010_0010);
    chk("multi_ss_low_cycles", 64'(ss_low), 64'd52);
    chk("multi_ss_runs", 64'(ss_runs), 64'd1);

    // Engine busy for 5 cycles on entry to LOAD.
    clear_logs();
    rx_key = 8'h99;
    t0 = cyc_n;
    fq[3].push_back({1'b1, 8'h77});
    step(3);
    eng_busy_x = 1'b1;
    step(5);
    eng_busy_x = 1'b0;
    wait_done("busy_timeout");
    chk("busy_start_delay", 64'(st_at(0) - t0), 64'd8);
    chk("busy_ready_same_cycle", 64'((rdy_cyc.size() == 1) && (rdy_cyc[0] == st_at(0))), 64'd1);
    chk("busy_ss_value", 64'(ss_seen), 64'h7);
    chk("busy_rsp", 64'(rsp_at(0)), 64'h3EE);

    // Reset during XFER, then a late eng_done.
    clear_logs();
    eng_auto = 1'b0;
    fq[0].push_back({1'b1, 8'hC3});
    step(6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_ss_n", 64'(ss_n), 64'hF);
    chk("abort_busy", 64'(busy), 64'd0);
    step(1);
    eng_done_x = 1'b1; rx_x = 8'hEE;
    step(1);
    eng_done_x = 1'b0;
    step(4);
    chk("abort_starts", 64'(st_cyc.size()), 64'd1);
    chk("abort_no_rsp", 64'(rsp_log.size()), 64'd0);
    chk("abort_idle", 64'({busy, ss_n}), 64'h0F);
    eng_auto = 1'b1;

    // Stray eng_done in IDLE, then in HOLD.
    clear_logs();
    eng_done_x = 1'b1; rx_x = 8'h55;
    step(1);
    eng_done_x = 1'b0;
    step(1);
    chk("stray_idle", 64'({busy, 1'b0, rsp_log.size() == 0}), 64'd1);
    t0 = cyc_n;
    fq[2].push_back({1'b1, 8'h5C});
    step(19);
    eng_done_x = 1'b1;
    step(1);
    eng_done_x = 1'b0;
    wait_done("stray_timeout");
    chk("stray_end_cycle", 64'(cyc_n - t0), 64'd22);
    chk("stray_rsp_count", 64'(rsp_log.size()), 64'd1);
    chk("stray_rsp", 64'(rsp_at(0)), 64'h2C5);
    chk("stray_ss_low_cycles", 64'(ss_low), 64'd20);

    chk("invariants", 64'(viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_frame_arbiter.md
# spi_frame_arbiter

Round-robin scheduler that shares one SPI byte engine (an 8-bit shift master with start/busy/done handshake) among up to eight requesters. Each requester owns one active-low slave select and submits a frame as a stream of bytes. The arbiter holds that slave select across the whole frame, enforces chip-select setup, hold and gap times, and routes each received byte back with the requester's ID. It sits between the client logic and the SPI master, and is the only block that drives `ss_n` and starts the engine.

## Interface
- `N_REQ`, 4, number of requesters/slaves; legal range 2..8.
- `CS_SETUP`, 2, clk cycles `ss_n` is low before the first byte starts; must be ≥1.
- `CS_HOLD`, 2, clk cycles `ss_n` stays low after the last byte's `eng_done`; must be ≥1.
- `CS_GAP`, 1, clk cycles all `ss_n` are high between frames; must be ≥1.

Ports:
- `clk`  in  1  single clock; every register is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  requester i has a byte pending.
- `req_last`  in  N_REQ  the pending byte is the last byte of its frame.
- `req_data`  in  8*N_REQ  byte for requester i, at bits [8i+7:8i].
- `req_ready`  out  N_REQ  one-hot; one-cycle pulse when requester i's byte is accepted.
- `rsp_valid`  out  1  one-cycle pulse; a received byte is on `rsp_data`.
- `rsp_id`  out  3  requester index for `rsp_data`.
- `rsp_data`  out  8  received byte.
- `eng_start`  out  1  one-cycle pulse that starts one byte transfer.
- `eng_tx`  out  8  byte to transmit; valid while `eng_start` is high.
- `eng_busy`  in  1  engine is shifting.
- `eng_done`  in  1  one-cycle pulse when the engine's byte is complete.
- `eng_rx`  in  8  received byte; valid with `eng_done`.
- `ss_n`  out  N_REQ  active-low slave selects.
- `busy`  out  1  a frame is in progress (any state other than IDLE).

## Operation
- States:
  - IDLE: no frame in progress.
  - SETUP: chip-select setup count.
  - LOAD: waiting to hand a byte to the engine.
  - XFER: waiting for the engine to finish the byte.
  - HOLD: chip-select hold count.
  - GAP: chip-select gap count.
- Registers: `grant` (3 bits), `last_q`, cycle counter, round-robin pointer `ptr`.
- IDLE:
  - Any `req_valid` high → `grant` = first index with `req_valid` set, searching `ptr+1`, `ptr+2`, … modulo N_REQ.
  - Then `ptr` ← `grant` and go to SETUP.
  - After reset `ptr` = N_REQ-1, so requester 0 has first priority.
- SETUP: `ss_n[grant]` low; stays CS_SETUP cycles, then LOAD.
- LOAD:
  - When `req_valid[grant]` && !`eng_busy`, in the same cycle: `eng_start`=1, `req_ready[grant]`=1, `eng_tx`=`req_data[grant]`.
  - Latch `last_q` ← `req_last[grant]`, then go to XFER.
  - `eng_start`, `req_ready` and `eng_tx` are combinational decodes of the registered state and the inputs.
  - If the requester drops `req_valid` mid-frame, the arbiter waits in LOAD indefinitely with `ss_n` held low. Other requesters are not served.
- XFER: on `eng_done`, capture `eng_rx` and `grant` into the `rsp_*` registers. Go to HOLD if `last_q` is set, else LOAD.
- HOLD: `ss_n[grant]` low for CS_HOLD cycles, then GAP.
- GAP: all `ss_n` high for CS_GAP cycles, then IDLE.
- `ss_n[grant]` is low from the first SETUP cycle through the last HOLD cycle. All other `ss_n` bits are high at all times.
- `eng_done` is ignored in every state except XFER.
- `req_valid` on non-granted requesters is ignored until the arbiter returns to IDLE.
- At most one `req_ready` bit is high in any cycle.

## Timing
- Reset values (cycle after `rst` high):
  - `ss_n` all ones; `req_ready`, `eng_start`, `rsp_valid`, `busy` = 0.
  - `rsp_id` = 0, `rsp_data` = 0, `eng_tx` = 0.
  - State IDLE, `ptr` = N_REQ-1, counters 0.
- Reset mid-frame:
  - The next cycle shows the reset values and `ss_n` releases immediately.
  - A later `eng_done` for the aborted byte produces no `rsp_valid`.
- `ss_n`, `busy` and the `rsp_*` outputs are registered.
- Frame timeline, with `req_valid` first seen in IDLE at cycle T:
  - `ss_n[g]` low from T+1.
  - Earliest `eng_start` at T+CS_SETUP+1.
  - `rsp_valid` is the cycle after `eng_done`.
  - HOLD starts that same cycle.
  - `ss_n[g]` high after CS_HOLD cycles.
  - Earliest next IDLE arbitration is CS_GAP cycles later.
- Back-to-back bytes in one frame: the next `eng_start` is no earlier than the cycle after `eng_done`. `ss_n` never toggles between bytes.

## Test plan
- **Single-byte frame:** reset, then requester 2 sends 0xA5 with `last`=1; the engine model takes 16 cycles and returns 0x3C.
  - `ss_n` goes 1111→1011 for 2 + 16 + 2 cycles, then back to 1111.
  - One `eng_start` with `eng_tx`=0xA5.
  - `rsp_valid` with `rsp_id`=2 and `rsp_data`=0x3C.
- **Round-robin order:** all four requesters assert single-byte frames together after reset.
  - Grants are 0, 1, 2, 3 in order.
  - Requester 0 re-asserts after its frame; the order is still 1, 2, 3, then 0.
- **Three-byte frame:** requester 1 sends 0x11, 0x22, 0x33, with `last` set only on 0x33.
  - `ss_n[1]` stays low continuously.
  - Three `req_ready[1]` pulses and three `rsp_valid` pulses, all with `rsp_id`=1.
  - HOLD occurs only after the third byte.
- **Engine busy:** `eng_busy` is held high for 5 cycles on entry to LOAD.
  - `eng_start` is deferred until the first cycle with `eng_busy`=0.
  - `req_ready` pulses in that same cycle.
- **Reset during XFER, then a late `eng_done`:**
  - `ss_n`=1111 and `busy`=0 the cycle after `rst`.
  - No `rsp_valid` follows.
- **Stray `eng_done` in IDLE and HOLD:**
  - No `rsp_valid`.
  - State sequence unchanged.
